// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined logic/arithmetic ALU.
// The opcode localparams keep the legacy encodings for the four original logic ops.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [2:0] {
    ALU_AND  = OP_AND,
    ALU_OR   = OP_OR,
    ALU_NAND = OP_NAND,
    ALU_NOR  = OP_NOR,
    ALU_XOR  = OP_XOR,
    ALU_XNOR = OP_XNOR,
    ALU_ADD  = OP_ADD,
    ALU_SUB  = OP_SUB
  } op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath: one WIDTH-bit operation plus zero, carry and sign flags.
// Carry is the no-borrow bit for SUB and is forced low for every logic op.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             z,
  output logic             n
);

  logic [WIDTH:0] sum_s;

  // Operation select; SUB is formed as A + ~B + 1 so the top bit reads as no-borrow
  always_comb begin
    sum_s  = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_NAND: result = ~(a & b);
      ALU_NOR:  result = ~(a | b);
      ALU_XOR:  result = a ^ b;
      ALU_XNOR: result = ~(a ^ b);
      ALU_ADD: begin
        sum_s  = {1'b0, a} + {1'b0, b};
        result = sum_s[WIDTH-1:0];
        c      = sum_s[WIDTH];
      end
      ALU_SUB: begin
        sum_s  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result = sum_s[WIDTH-1:0];
        c      = sum_s[WIDTH];
      end
      default: result = '0;
    endcase
  end

  assign z = (result == '0);
  assign n = result[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with an accumulator that can replace operand A.
// The accumulator is substituted at the S1->S2 transfer so dependent ops chain without stalls.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n
);

  logic             v1_r;
  op_t              op1_r;
  logic             acc_sel1_r;
  logic [WIDTH-1:0] a1_r;
  logic [WIDTH-1:0] b1_r;
  logic [WIDTH-1:0] acc_r;

  logic             advance_s;
  logic             accept_s;
  logic             xfer_s;
  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] core_result_s;
  logic             core_c_s;
  logic             core_z_s;
  logic             core_n_s;

  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = ~v1_r | advance_s;
  assign accept_s  = in_valid & in_ready;
  assign xfer_s    = advance_s & v1_r;

  // Operand A source for the op leaving S1
  always_comb begin
    opa_s = '0;
    if (acc_sel1_r) begin
      opa_s = acc_r;
    end else begin
      opa_s = a1_r;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op1_r),
    .a      (opa_s),
    .b      (b1_r),
    .result (core_result_s),
    .c      (core_c_s),
    .z      (core_z_s),
    .n      (core_n_s)
  );

  // Pipeline registers, accumulator and handshake state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r       <= 1'b0;
      op1_r      <= ALU_AND;
      acc_sel1_r <= 1'b0;
      a1_r       <= '0;
      b1_r       <= '0;
      acc_r      <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_n     <= 1'b0;
    end else begin
      if (accept_s) begin
        v1_r       <= 1'b1;
        op1_r      <= op_t'(op);
        acc_sel1_r <= acc_sel;
        a1_r       <= a;
        b1_r       <= b;
      end else if (xfer_s) begin
        v1_r <= 1'b0;
      end
      // A consumed result is overwritten in the same cycle when S1 has a follow-up
      if (xfer_s) begin
        out_valid <= 1'b1;
        result    <= core_result_s;
        flag_z    <= core_z_s;
        flag_c    <= core_c_s;
        flag_n    <= core_n_s;
        acc_r     <= core_result_s;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed WIDTH=8 checks plus a randomized WIDTH=16 sweep
// scored against an arithmetic reference model with a result queue.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid8 = 1'b0, in_ready8, acc_sel8 = 1'b0, out_valid8, out_ready8 = 1'b1;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, result8;
  logic        flag_z8, flag_c8, flag_n8;

  logic        in_valid16 = 1'b0, in_ready16, acc_sel16 = 1'b0, out_valid16, out_ready16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0, result16;
  logic        flag_z16, flag_c16, flag_n16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .acc_sel(acc_sel8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flag_z(flag_z8), .flag_c(flag_c8), .flag_n(flag_n8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .acc_sel(acc_sel16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .flag_z(flag_z16), .flag_c(flag_c16), .flag_n(flag_n16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Packed payload layout shared by model and DUT samples: c@18, z@17, n@16, result@15:0
  function automatic logic [31:0] pk(input logic c, input logic z, input logic n, input logic [15:0] r);
    return {13'd0, c, z, n, r};
  endfunction

  function automatic logic [31:0] pl8();
    return pk(flag_c8, flag_z8, flag_n8, {8'd0, result8});
  endfunction

  function automatic logic [31:0] pl16();
    return pk(flag_c16, flag_z16, flag_n16, result16);
  endfunction

  // Reference behaviour straight from the op table, using unbounded integer arithmetic
  function automatic logic [31:0] ref_alu(input int op, input longint x, input longint y, input int w);
    longint m = (longint'(1) << w) - 1;
    longint r = 0;
    logic   c = 1'b0;
    case (op)
      0: r = x & y;
      1: r = x | y;
      2: r = ~(x & y) & m;
      3: r = ~(x | y) & m;
      4: r = x ^ y;
      5: r = ~(x ^ y) & m;
      6: begin r = (x + y) & m; c = (x + y) > m; end
      7: begin r = (x - y) & m; c = (x >= y); end
      default: r = 0;
    endcase
    return pk(c, r == 0, r[w-1], 16'(r));
  endfunction

  task automatic drive8(input logic [2:0] o, input logic s, input logic [7:0] x, input logic [7:0] y);
    in_valid8 = 1'b1; op8 = o; acc_sel8 = s; a8 = x; b8 = y;
  endtask

  // Single op through an idle pipe with out_ready high; result checked one edge after acceptance
  task automatic run8(input string tag, input logic [2:0] o, input logic s,
                      input logic [7:0] x, input logic [7:0] y, input logic [31:0] exp);
    @(negedge clk);
    check_eq({tag, "_rdy"}, 32'(in_ready8), 32'd1);
    drive8(o, s, x, y);
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ov"}, 32'(out_valid8), 32'd1);
    check_eq(tag, pl8(), exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bp_exp[3];
    logic [31:0] got_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] e, pl, prev_pl;
    logic [15:0] acc_m;
    logic        acc_now, stall_prev;
    int          idx, consumed, cyc;
    logic [2:0]  bp_op[3];
    logic [7:0]  bp_a[3], bp_b[3];

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ov", 32'(out_valid8), 32'd0);
    check_eq("rst_res", pl8(), 32'd0);
    check_eq("rst_rdy", 32'(in_ready8), 32'd1);

    run8("and",  3'b000, 1'b0, 8'hF0, 8'h3C, pk(1'b0, 1'b0, 1'b0, 16'h0030));
    run8("nor",  3'b011, 1'b0, 8'hF0, 8'h3C, pk(1'b0, 1'b0, 1'b0, 16'h0003));
    run8("nand", 3'b010, 1'b0, 8'hFF, 8'hFF, pk(1'b0, 1'b1, 1'b0, 16'h0000));
    run8("or",   3'b001, 1'b0, 8'hF0, 8'h3C, pk(1'b0, 1'b0, 1'b1, 16'h00FC));
    run8("xor",  3'b100, 1'b0, 8'hAA, 8'h0F, pk(1'b0, 1'b0, 1'b1, 16'h00A5));
    run8("xnor", 3'b101, 1'b0, 8'hAA, 8'h0F, pk(1'b0, 1'b0, 1'b0, 16'h005A));
    run8("add_wrap", 3'b110, 1'b0, 8'hFF, 8'h01, pk(1'b1, 1'b1, 1'b0, 16'h0000));
    run8("sub_borrow", 3'b111, 1'b0, 8'h05, 8'h07, pk(1'b0, 1'b0, 1'b1, 16'h00FE));
    run8("sub_ok", 3'b111, 1'b0, 8'h07, 8'h05, pk(1'b1, 1'b0, 1'b0, 16'h0002));

    // Accumulator chain on consecutive cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check_eq("chain_ov", 32'(out_valid8), 32'd1);
        check_eq("chain_res", 32'(result8), 32'h11 + 32'(i - 2));
      end
      if (i == 0) drive8(3'b110, 1'b0, 8'h10, 8'h01);
      else if (i < 3) drive8(3'b110, 1'b1, 8'hEE, 8'h01);
      else in_valid8 = 1'b0;
    end

    // Backpressure: five stalled cycles, three ops offered
    bp_op[0] = 3'b110; bp_a[0] = 8'h20; bp_b[0] = 8'h03;
    bp_op[1] = 3'b100; bp_a[1] = 8'h0F; bp_b[1] = 8'hFF;
    bp_op[2] = 3'b111; bp_a[2] = 8'h10; bp_b[2] = 8'h01;
    for (int i = 0; i < 3; i++) bp_exp[i] = ref_alu(int'(bp_op[i]), longint'(bp_a[i]), longint'(bp_b[i]), 8);
    @(negedge clk);
    out_ready8 = 1'b0;
    idx = 0;
    drive8(bp_op[0], 1'b0, bp_a[0], bp_b[0]);
    for (int cyc_i = 0; cyc_i < 10; cyc_i++) begin
      if (cyc_i > 0) @(negedge clk);
      if (cyc_i >= 2 && cyc_i <= 4) begin
        check_eq("bp_rdy", 32'(in_ready8), 32'd0);
        check_eq("bp_ov", 32'(out_valid8), 32'd1);
        check_eq("bp_hold", pl8(), bp_exp[0]);
      end
      if (cyc_i == 4) check_eq("bp_accepted", 32'(idx), 32'd2);
      if (out_valid8 && out_ready8) got_q.push_back(pl8());
      acc_now = in_valid8 && in_ready8;
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 3) drive8(bp_op[idx], 1'b0, bp_a[idx], bp_b[idx]);
        else in_valid8 = 1'b0;
      end
      if (cyc_i == 4) out_ready8 = 1'b1;
    end
    check_eq("bp_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > 0) check_eq("bp_order", got_q.pop_front(), bp_exp[i]);
    end

    // Reset with both stages occupied
    @(negedge clk);
    out_ready8 = 1'b0;
    drive8(3'b110, 1'b0, 8'h01, 8'h01);
    @(negedge clk);
    drive8(3'b110, 1'b0, 8'h02, 8'h02);
    @(negedge clk);
    in_valid8 = 1'b0;
    check_eq("prerst_ov", 32'(out_valid8), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst2_ov", 32'(out_valid8), 32'd0);
    check_eq("rst2_res", pl8(), 32'd0);
    check_eq("rst2_rdy", 32'(in_ready8), 32'd1);
    out_ready8 = 1'b1;
    @(negedge clk);
    check_eq("rst2_drain", 32'(out_valid8), 32'd0);
    run8("rst2_acc", 3'b110, 1'b1, 8'h55, 8'h04, pk(1'b0, 1'b0, 1'b0, 16'h0004));

    // Random sweep at WIDTH=16
    acc_m = 16'd0; consumed = 0; cyc = 0; stall_prev = 1'b0; prev_pl = 32'd0;
    while (consumed < 10000 && cyc < 60000) begin
      @(posedge clk);
      #1;
      cyc++;
      in_valid16  = ($urandom_range(3) != 0);
      op16        = 3'($urandom);
      acc_sel16   = ($urandom_range(3) == 0);
      a16         = 16'($urandom);
      b16         = ($urandom_range(7) == 0) ? a16 : 16'($urandom);
      out_ready16 = ($urandom_range(3) != 0);
      @(negedge clk);
      pl = pl16();
      if (stall_prev) begin
        check_eq("rnd_hold_ov", 32'(out_valid16), 32'd1);
        check_eq("rnd_hold_pl", pl, prev_pl);
      end
      stall_prev = out_valid16 && !out_ready16;
      prev_pl = pl;
      if (out_valid16 && out_ready16) begin
        if (sb_q.size() == 0) check_eq("rnd_extra_out", 32'(out_valid16), 32'd0);
        else check_eq("rnd", pl, sb_q.pop_front());
        consumed++;
      end
      if (in_valid16 && in_ready16) begin
        e = ref_alu(int'(op16), longint'(acc_sel16 ? acc_m : a16), longint'(b16), 16);
        acc_m = e[15:0];
        sb_q.push_back(e);
      end
    end
    if (consumed < 10000) check_eq("rnd_timeout", 32'(consumed), 32'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
